// File: rtl/fpu_issue_ctrl.sv
// Multi-cycle FPU issue/stall controller: accepts a decoded FP op, holds the
// pipeline for the op's latency, then presents a one-cycle writeback packet.
module fpu_issue_ctrl #(
    parameter int unsigned LAT_ADD  = 3,
    parameter int unsigned LAT_MUL  = 4,
    parameter int unsigned LAT_DIV  = 12,
    parameter int unsigned LAT_SQRT = 14,
    parameter int unsigned LAT_MISC = 1,
    parameter int unsigned LAT_CVT  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    input  logic [3:0]  op_sel,
    input  logic [4:0]  rd_in,
    input  logic        fp_wr_in,
    input  logic        int_wr_in,
    input  logic        flush,
    input  logic [31:0] fpu_result_in,
    output logic        fpu_start,
    output logic [3:0]  fpu_op,
    output logic        stall,
    output logic        busy,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_fp,
    output logic        wb_int,
    output logic [31:0] wb_data,
    output logic        illegal
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  op_q;
    logic [4:0]  rd_q;
    logic        fp_q, int_q;
    logic [31:0] data_q;
    logic [3:0]  lat_sel;
    logic        legal, offer, accept;

    assign legal  = (op_sel <= 4'd9);
    assign offer  = (state != RUN) && issue_valid && !flush;
    assign accept = offer && legal;

    always_comb begin
        lat_sel = 4'(LAT_MISC);
        case (op_sel)
            4'd0, 4'd1: lat_sel = 4'(LAT_ADD);
            4'd2:       lat_sel = 4'(LAT_MUL);
            4'd3:       lat_sel = 4'(LAT_DIV);
            4'd6:       lat_sel = 4'(LAT_SQRT);
            4'd8, 4'd9: lat_sel = 4'(LAT_CVT);
            default:    lat_sel = 4'(LAT_MISC);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = accept ? RUN : IDLE;
                RUN:     state_nxt = (cnt == 4'd1) ? DONE : RUN;
                DONE:    state_nxt = accept ? RUN : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // fpu_op survives a flush; only the writeback destination fields are cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            op_q   <= '0;
            rd_q   <= '0;
            fp_q   <= 1'b0;
            int_q  <= 1'b0;
            data_q <= '0;
        end else if (flush) begin
            cnt   <= '0;
            rd_q  <= '0;
            fp_q  <= 1'b0;
            int_q <= 1'b0;
        end else if (accept) begin
            cnt   <= lat_sel;
            op_q  <= op_sel;
            rd_q  <= rd_in;
            fp_q  <= fp_wr_in;
            int_q <= int_wr_in;
        end else if (state == RUN) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) data_q <= fpu_result_in;
        end
    end

    always_comb begin
        fpu_start = accept;
        stall     = accept || ((state == RUN) && !flush);
        busy      = (state == RUN);
        wb_valid  = (state == DONE) && !flush;
        wb_rd     = wb_valid ? rd_q : '0;
        wb_fp     = wb_valid && fp_q;
        wb_int    = wb_valid && int_q;
        wb_data   = data_q;
        illegal   = offer && !legal;
        fpu_op    = op_q;
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: table-driven op latencies plus
// back-to-back, illegal, flush and async-reset sequences; writebacks scoreboarded.
module tb_fpu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic [3:0]  op_sel;
    logic [4:0]  rd_in;
    logic        fp_wr_in;
    logic        int_wr_in;
    logic        flush;
    logic [31:0] fpu_result_in;
    logic        fpu_start;
    logic [3:0]  fpu_op;
    logic        stall;
    logic        busy;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_fp;
    logic        wb_int;
    logic [31:0] wb_data;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        fp;
        logic        iw;
        logic [31:0] data;
        int unsigned lat;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic        fp;
        logic        iw;
        logic [31:0] data;
    } wb_t;

    wb_t  sb[$];
    vec_t vecs[10];

    fpu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .op_sel(op_sel),
        .rd_in(rd_in), .fp_wr_in(fp_wr_in), .int_wr_in(int_wr_in), .flush(flush),
        .fpu_result_in(fpu_result_in), .fpu_start(fpu_start), .fpu_op(fpu_op),
        .stall(stall), .busy(busy), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_fp(wb_fp), .wb_int(wb_int), .wb_data(wb_data), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every writeback strobe must match the oldest pending expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", {31'd0, wb_valid}, 32'd0);
            end else begin
                wb_t e;
                e = sb.pop_front();
                chk("wb_rd",   {27'd0, wb_rd},  {27'd0, e.rd});
                chk("wb_fp",   {31'd0, wb_fp},  {31'd0, e.fp});
                chk("wb_int",  {31'd0, wb_int}, {31'd0, e.iw});
                chk("wb_data", wb_data, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [4:0] rd, input logic fp,
                         input logic iw, input logic [31:0] data, input bit push);
        issue_valid   = 1'b1;
        op_sel        = op;
        rd_in         = rd;
        fp_wr_in      = fp;
        int_wr_in     = iw;
        fpu_result_in = ~data;
        if (push) sb.push_back('{rd, fp, iw, data});
        @(negedge clk);
        chk("start_on_accept", {31'd0, fpu_start}, 32'd1);
        chk("stall_on_accept", {31'd0, stall}, 32'd1);
        chk("no_illegal",      {31'd0, illegal}, 32'd0);
    endtask

    // Result is only valid in the final RUN cycle so an early/late capture is caught
    task automatic expect_run(input logic [3:0] op, input logic [31:0] data, input int unsigned lat);
        for (int unsigned k = 1; k <= lat; k++) begin
            tick();
            issue_valid   = 1'b0;
            fpu_result_in = (k == lat) ? data : ~data;
            @(negedge clk);
            chk("run_stall",    {31'd0, stall}, 32'd1);
            chk("run_busy",     {31'd0, busy}, 32'd1);
            chk("run_no_wb",    {31'd0, wb_valid}, 32'd0);
            chk("run_fpu_op",   {28'd0, fpu_op}, {28'd0, op});
            chk("run_no_start", {31'd0, fpu_start}, 32'd0);
        end
    endtask

    task automatic expect_done();
        tick();
        issue_valid   = 1'b0;
        fpu_result_in = $urandom;
        @(negedge clk);
        chk("done_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("done_stall",    {31'd0, stall}, 32'd0);
        chk("done_busy",     {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        issue_valid   = 1'b0;
        op_sel        = '0;
        rd_in         = '0;
        fp_wr_in      = 1'b0;
        int_wr_in     = 1'b0;
        flush         = 1'b0;
        fpu_result_in = '0;

        vecs[0] = '{4'd0, 5'd5,  1'b1, 1'b0, 32'h3FC0_0000, 3};
        vecs[1] = '{4'd1, 5'd6,  1'b1, 1'b0, 32'hBF80_0000, 3};
        vecs[2] = '{4'd2, 5'd7,  1'b1, 1'b0, 32'h4080_0000, 4};
        vecs[3] = '{4'd3, 5'd8,  1'b1, 1'b0, 32'h3EAA_AAAB, 12};
        vecs[4] = '{4'd4, 5'd9,  1'b1, 1'b0, 32'h8000_0001, 1};
        vecs[5] = '{4'd5, 5'd10, 1'b1, 1'b0, 32'h7F7F_FFFF, 1};
        vecs[6] = '{4'd6, 5'd11, 1'b1, 1'b0, 32'h3FB5_04F3, 14};
        vecs[7] = '{4'd7, 5'd12, 1'b0, 1'b1, 32'h0000_0001, 1};
        vecs[8] = '{4'd8, 5'd13, 1'b0, 1'b1, 32'hFFFF_FFF9, 2};
        vecs[9] = '{4'd9, 5'd31, 1'b1, 1'b0, 32'hC0E0_0000, 2};

        #2;
        chk("rst_stall",   {31'd0, stall}, 32'd0);
        chk("rst_busy",    {31'd0, busy}, 32'd0);
        chk("rst_wb",      {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_fpu_op",  {28'd0, fpu_op}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            tick();
            issue(vecs[i].op, vecs[i].rd, vecs[i].fp, vecs[i].iw, vecs[i].data, 1'b1);
            expect_run(vecs[i].op, vecs[i].data, vecs[i].lat);
            expect_done();
            tick();
            @(negedge clk);
            chk("idle_after_wb", {29'd0, busy, stall, wb_valid}, 32'd0);
        end

        // FDIV then FMUL accepted in the DIV's DONE cycle
        tick();
        issue(4'd3, 5'd3, 1'b1, 1'b0, 32'h4049_0FDB, 1'b1);
        expect_run(4'd3, 32'h4049_0FDB, 12);
        tick();
        issue(4'd2, 5'd4, 1'b1, 1'b0, 32'h4120_0000, 1'b1);
        chk("b2b_wb_valid", {31'd0, wb_valid}, 32'd1);
        expect_run(4'd2, 32'h4120_0000, 4);
        expect_done();

        // Illegal selector
        tick();
        issue_valid = 1'b1;
        op_sel      = 4'd12;
        rd_in       = 5'd1;
        @(negedge clk);
        chk("ill_pulse", {31'd0, illegal}, 32'd1);
        chk("ill_stall", {31'd0, stall}, 32'd0);
        chk("ill_start", {31'd0, fpu_start}, 32'd0);
        tick();
        issue_valid = 1'b0;
        @(negedge clk);
        chk("ill_one_cycle", {31'd0, illegal}, 32'd0);
        chk("ill_no_run",    {31'd0, busy}, 32'd0);

        // FSQRT flushed at T+5
        tick();
        issue(4'd6, 5'd20, 1'b1, 1'b0, 32'h1234_5678, 1'b0);
        expect_run(4'd6, 32'h1234_5678, 4);
        tick();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_stall", {31'd0, stall}, 32'd0);
        chk("flush_wb",    {31'd0, wb_valid}, 32'd0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_idle", {31'd0, busy}, 32'd0);
        repeat (16) begin
            tick();
            @(negedge clk);
            chk("flush_no_wb", {30'd0, wb_valid, stall}, 32'd0);
        end

        // Async reset at T+2 of an FDIV
        tick();
        issue(4'd3, 5'd21, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
        tick();
        issue_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("arst_stall",   {31'd0, stall}, 32'd0);
        chk("arst_busy",    {31'd0, busy}, 32'd0);
        chk("arst_start",   {31'd0, fpu_start}, 32'd0);
        chk("arst_wb",      {26'd0, wb_valid, wb_rd}, 32'd0);
        chk("arst_wb_data", wb_data, 32'd0);
        chk("arst_fpu_op",  {28'd0, fpu_op}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        issue(4'd0, 5'd5, 1'b1, 1'b0, 32'h3FC0_0000, 1'b1);
        expect_run(4'd0, 32'h3FC0_0000, 3);
        expect_done();

        repeat (20) tick();
        chk("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
